// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin 2:1 valid/ready arbiter with registered output stage
// Optional saturating per-channel grant counters when MUX2_ARB_CNT_EN is defined.
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
`ifdef MUX2_ARB_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel
`ifdef MUX2_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt_a,
  output logic [CNT_W-1:0] grant_cnt_b
`endif
);

  logic prio;
  logic space;
  logic grant_a;
  logic grant_b;
  logic accept_a;
  logic accept_b;

  // prio=0 favours A on contention; a lone requester always wins.
  assign grant_a  = a_valid && (!b_valid || !prio);
  assign grant_b  = b_valid && (!a_valid || prio);
  assign space    = !out_valid || out_ready;

  // rst_n gating keeps both readies low while the register is held in reset.
  assign a_ready  = rst_n && space && grant_a;
  assign b_ready  = rst_n && space && grant_b;
  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel       <= 1'b0;
      prio      <= 1'b0;
    end else if (accept_a || accept_b) begin
      out_data  <= accept_b ? b_data : a_data;
      sel       <= accept_b;
      out_valid <= 1'b1;
      prio      <= !accept_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX2_ARB_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else begin
      if (accept_a && grant_cnt_a != CNT_MAX)
        grant_cnt_a <= grant_cnt_a + 1'b1;
      if (accept_b && grant_cnt_b != CNT_MAX)
        grant_cnt_b <= grant_cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed self-checking bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       sel;
`ifdef MUX2_ARB_CNT_EN
  logic [1:0] grant_cnt_a;
  logic [1:0] grant_cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef MUX2_ARB_CNT_EN
  mux2_rr_arbiter #(.WIDTH(8), .CNT_W(2)) dut (
`else
  mux2_rr_arbiter #(.WIDTH(8)) dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel)
`ifdef MUX2_ARB_CNT_EN
    , .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // 1: reset with random inputs
    a_data = 8'($urandom); b_data = 8'($urandom);
    a_valid = 1'b1; b_valid = 1'($urandom); out_ready = 1'($urandom);
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    do_reset();

    // 2: A only
    a_valid = 1'b1; a_data = 8'h05; b_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("aonly_a_ready", 32'(a_ready), 32'd1);
    check("aonly_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    check("aonly_data", 32'(out_data), 32'h05);
    check("aonly_valid", 32'(out_valid), 32'd1);
    check("aonly_sel", 32'(sel), 32'd0);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data_hold", 32'(out_data), 32'h05);

    // 3: contention alternates starting with A after reset
    do_reset();
    a_data = 8'h03; b_data = 8'h06; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("cont_data%0d", i), 32'(out_data), (i % 2 == 0) ? 32'h03 : 32'h06);
      check($sformatf("cont_sel%0d", i), 32'(sel), 32'(i % 2));
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // 4: backpressure holds 07; prio now favours A (last winner B)
    a_valid = 1'b1; a_data = 8'h07;
    tick();
    check("bp_load", 32'(out_data), 32'h07);
    out_ready = 1'b0; a_data = 8'h08; b_valid = 1'b1; b_data = 8'h09;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_a_ready%0d", i), 32'(a_ready), 32'd0);
      check($sformatf("bp_b_ready%0d", i), 32'(b_ready), 32'd0);
      tick();
      check($sformatf("bp_data%0d", i), 32'(out_data), 32'h07);
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_b_ready", 32'(b_ready), 32'd1);
    check("bp_rel_a_ready", 32'(a_ready), 32'd0);
    tick();
    check("bp_rel_data", 32'(out_data), 32'h09);
    check("bp_rel_sel", 32'(sel), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;

    // 5: mid-op async reset discards held word
    a_valid = 1'b1; a_data = 8'h02;
    tick();
    a_valid = 1'b0; out_ready = 1'b0;
    check("mid_hold", 32'(out_data), 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'h00);
    tick();
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22; out_ready = 1'b1;
    #1;
    check("post_rst_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("post_rst_data", 32'(out_data), 32'h11);
    check("post_rst_sel", 32'(sel), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;

`ifdef MUX2_ARB_CNT_EN
    // 6: saturating counters with CNT_W=2
    do_reset();
    a_valid = 1'b1; a_data = 8'h01; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    a_valid = 1'b0;
    check("cnt_a_sat", 32'(grant_cnt_a), 32'd3);
    check("cnt_b_zero", 32'(grant_cnt_b), 32'd0);
    b_valid = 1'b1; b_data = 8'h0b;
    tick();
    b_valid = 1'b0;
    check("cnt_b_one", 32'(grant_cnt_b), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
